// File: rtl/dsp_mul_arbiter.sv
// Round-robin front end that shares one pipelined signed multiplier among
// NUM_REQ requesters and returns each product tagged with its requester ID.
module dsp_mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned A_WIDTH     = 16,
  parameter int unsigned B_WIDTH     = 16,
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_hold,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*A_WIDTH-1:0]   i_req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic [A_WIDTH-1:0]           o_mul_a,
  output logic [B_WIDTH-1:0]           o_mul_b,
  input  logic [A_WIDTH+B_WIDTH:0]     i_mul_p,
  output logic                         o_rsp_valid,
  output logic [ID_WIDTH-1:0]          o_rsp_id,
  output logic [A_WIDTH+B_WIDTH:0]     o_rsp_p,
  output logic                         o_busy
);

  // One extra bit so ptr + offset can exceed NUM_REQ before the wrap compare.
  localparam int unsigned CW = ID_WIDTH + 1;

  typedef struct packed {
    logic                v;
    logic [ID_WIDTH-1:0] id;
  } tag_t;

  logic [ID_WIDTH-1:0]        r_ptr;
  tag_t                       r_iss;
  tag_t [MUL_LATENCY-1:0]     r_pipe;
  logic [A_WIDTH-1:0]         r_mul_a;
  logic [B_WIDTH-1:0]         r_mul_b;
  logic                       r_rsp_valid;
  logic [ID_WIDTH-1:0]        r_rsp_id;
  logic [A_WIDTH+B_WIDTH:0]   r_rsp_p;

  logic [CW-1:0]              w_cand;
  logic                       w_found;
  logic [ID_WIDTH-1:0]        w_grant_idx;
  logic                       w_grant;
  logic [ID_WIDTH-1:0]        w_next_ptr;
  logic [A_WIDTH-1:0]         w_sel_a;
  logic [B_WIDTH-1:0]         w_sel_b;
  logic                       w_pipe_any;

  // Search for the first valid requester starting at ptr, wrapping at NUM_REQ.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + CW'(k);
      if (w_cand >= CW'(NUM_REQ)) begin
        w_cand = w_cand - CW'(NUM_REQ);
      end
      if (!w_found && i_req_valid[w_cand[ID_WIDTH-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand[ID_WIDTH-1:0];
      end
    end
  end

  assign w_grant = w_found & ~i_reset & ~i_hold;

  always_comb begin
    o_req_ready = '0;
    if (w_grant) begin
      o_req_ready = NUM_REQ'(1) << w_grant_idx;
    end
  end

  assign w_next_ptr = (w_grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                               : w_grant_idx + ID_WIDTH'(1);

  // Operand mux on the granted index.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant_idx == ID_WIDTH'(k)) begin
        w_sel_a = i_req_a[k*A_WIDTH +: A_WIDTH];
        w_sel_b = i_req_b[k*B_WIDTH +: B_WIDTH];
      end
    end
  end

  always_comb begin
    w_pipe_any = 1'b0;
    for (int unsigned s = 0; s < MUL_LATENCY; s++) begin
      w_pipe_any = w_pipe_any | r_pipe[s].v;
    end
  end

  // Issue stage, tag shift register and response capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr       <= '0;
      r_iss       <= '0;
      r_pipe      <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_p     <= '0;
    end else begin
      if (w_grant) begin
        r_ptr   <= w_next_ptr;
        r_mul_a <= w_sel_a;
        r_mul_b <= w_sel_b;
      end
      r_iss.v  <= w_grant;
      r_iss.id <= w_grant_idx;
      r_pipe[0] <= r_iss;
      for (int unsigned s = 1; s < MUL_LATENCY; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
      r_rsp_valid <= r_pipe[MUL_LATENCY-1].v;
      if (r_pipe[MUL_LATENCY-1].v) begin
        r_rsp_id <= r_pipe[MUL_LATENCY-1].id;
        r_rsp_p  <= i_mul_p;
      end
    end
  end

  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_p     = r_rsp_p;
  assign o_busy      = r_iss.v | w_pipe_any | r_rsp_valid;

endmodule

// File: doc/dsp_mul_arbiter.md
Name: dsp_mul_arbiter

Overview:
- Round-robin scheduler that shares one pipelined signed multiplier (clk, reset, A, B, P style) among NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier operand registers.
- Tracks each in-flight operation's requester ID through the multiplier pipeline and returns the product tagged with that ID.
- Sits between several DSP-consuming clients and a single hard multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- A_WIDTH, 16, operand A width, signed.
- B_WIDTH, 16, operand B width, signed.
- MUL_LATENCY, 1, cycles from mul_a/mul_b valid to mul_p valid in the attached multiplier (1..4).
- ID_WIDTH, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears all state; also wired to the attached multiplier.
- hold  in  1  when 1, no new requests are granted; in-flight operations still drain.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*A_WIDTH  packed operand A, requester i at bits [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  packed operand B, same packing.
- req_ready  out  NUM_REQ  one-hot-or-zero grant; the handshake completes when req_valid[i] & req_ready[i].
- mul_a  out  A_WIDTH  registered operand to the multiplier.
- mul_b  out  B_WIDTH  registered operand to the multiplier.
- mul_p  in  A_WIDTH+B_WIDTH+1  signed product from the multiplier.
- rsp_valid  out  1  one-cycle pulse per completed product.
- rsp_id  out  ID_WIDTH  requester index of the product.
- rsp_p  out  A_WIDTH+B_WIDTH+1  product, registered copy of mul_p.
- busy  out  1  1 while any operation is in flight (issue stage, multiplier pipeline, or response register).

Behaviour:
- Reset values:
  - req_ready = 0, mul_a = 0, mul_b = 0, rsp_valid = 0, rsp_id = 0, rsp_p = 0, busy = 0.
  - Round-robin pointer = 0; all tag valid bits = 0.
  - reset takes priority over every other input, including mid-operation. In-flight operations are discarded and never produce rsp_valid.
- Arbitration (combinational):
  - If reset = 0 and hold = 0, grant the first i with req_valid[i] = 1, searching from ptr upward with wrap at NUM_REQ.
  - req_ready[grant] = 1; all other bits are 0. At most one grant per cycle.
  - req_ready never depends on anything other than req_valid, ptr, hold and reset.
- Pointer:
  - On a grant to i, ptr <= (i+1) mod NUM_REQ.
  - With no grant, ptr holds its value.
  - Continuous requests from all requesters are served strictly 0,1,2,...,NUM_REQ-1,0,...
- Issue stage: on a grant, the next edge registers mul_a <= req_a[i] and mul_b <= req_b[i], and sets tag valid = 1 with tag id = i. Otherwise mul_a and mul_b hold their values and tag valid = 0.
- Tag pipeline: a shift register of depth MUL_LATENCY carries {valid, id} alongside the multiplier. It advances every cycle and never stalls.
- Response: when the tag pipeline's last stage is valid, the next edge sets rsp_valid = 1, rsp_id = id, rsp_p = mul_p. Otherwise rsp_valid = 0 and rsp_p/rsp_id hold their values.
- Latency: a handshake at edge n produces rsp_valid high in the cycle after edge n+1+MUL_LATENCY (2+MUL_LATENCY edges inclusive). Throughput is one product per cycle.
- Responses have no backpressure and are returned in grant order.
- Arithmetic:
  - Operands are signed two's complement; the product is a full-precision signed value sign-extended to A_WIDTH+B_WIDTH+1 bits.
  - The arbiter passes mul_p through unmodified.
- hold:
  - Asserting hold forces req_ready = 0 in the same cycle.
  - Operations already granted complete normally.
  - Deasserting hold resumes arbitration from the current ptr.
- busy = OR of the issue-stage tag valid, all tag-pipeline valid bits, and rsp_valid.
- Boundary cases:
  - NUM_REQ not a power of two: pointer wrap uses explicit compare, not truncation.
  - A request with valid high and not granted must stay stable (requester rule); the arbiter holds no copy of it.

Test Plan:
- Reset: assert reset for 2 edges with all req_valid = 1 → req_ready = 0, rsp_valid = 0, mul_a = mul_b = 0, busy = 0; first grant after release goes to requester 0.
- Single request (MUL_LATENCY = 1): requester 2 sends A = 5, B = 2 → req_ready = 4'b0100 in the same cycle; 3 edges later rsp_valid = 1, rsp_id = 2, rsp_p = 10, as a single-cycle pulse.
- Fairness: all 4 req_valid held high for 8 cycles with A = i+1, B = 10 → grants 0,1,2,3,0,1,2,3; responses in order with rsp_p = 10,20,30,40,...; no idle cycles.
- Signed extremes: A = -3, B = 7 → rsp_p = -21; A = -32768, B = -32768 → rsp_p = 1073741824; A = 32767, B = -32768 → rsp_p = -1073709056.
- hold: requesters 1 and 3 pending, hold asserted for 5 cycles right after a grant to 1 → no further req_ready; requester 1's response still arrives; busy falls to 0; after release requester 3 is granted next.
- Reset mid-flight: grant requester 0, assert reset on the following edge → no rsp_valid for that operation, busy = 0, ptr restarts at 0.
